hpdmc_ddr_datapath: RTL

Burst data-path sequencer directly upstream of the DDR I/O stage. It accepts read/write burst starts from the command scheduler and drives direction, direction_r, mo and do toward the DDR I/O block at the correct command-to-data latency. It captures the di words returned by that block and presents them to the bus interface as a valid-qualified read stream. All timing is counted in sys_clk cycles, with one 32-bit word (two DDR beats) per cycle.

---
 rtl/hpdmc_ddr_datapath_if.sv | 32 +++
 rtl/hpdmc_ddr_datapath.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/hpdmc_ddr_datapath_if.sv
// Signal bundle between the DDR burst data-path sequencer and its neighbours:
// command scheduler, bus interface and the DDR I/O stage.
interface hpdmc_ddr_datapath_if;
   logic        wr_start;
   logic        rd_start;
   logic        busy;
   logic        protocol_err;
   logic        wr_ack;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        direction;
   logic        direction_r;
   logic [3:0]  mo;
   logic [31:0] dout;
   logic [31:0] di;

   // slave: the sequencer itself
   modport slave (
      input  wr_start, rd_start, wr_data, wr_be, di,
      output busy, protocol_err, wr_ack, rd_valid, rd_data,
             direction, direction_r, mo, dout
   );

   // master: scheduler, bus interface and I/O stage seen as one peer
   modport master (
      output wr_start, rd_start, wr_data, wr_be, di,
      input  busy, protocol_err, wr_ack, rd_valid, rd_data,
             direction, direction_r, mo, dout
   );
endinterface

// File: rtl/hpdmc_ddr_datapath.sv
// Burst data-path sequencer feeding the DDR I/O stage: places write words and
// masks at the write latency and captures read words at the read latency.
module hpdmc_ddr_datapath #(
   parameter int BURST = 4,
   parameter int CL_WR = 1,
   parameter int CL_RD = 3
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   hpdmc_ddr_datapath_if.slave  bus
);

   localparam int CNT_MAX_RB = (CL_RD > BURST) ? CL_RD : BURST;
   localparam int CNT_MAX    = (CL_WR > CNT_MAX_RB) ? CL_WR : CNT_MAX_RB;
   localparam int CNT_W      = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      IDLE,
      WR_LAT,
      WR_BURST,
      WR_POST,
      RD_LAT,
      RD_BURST,
      TURN
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             err_nx;
   logic             rd_mask_nx;

   // Next-state logic: cnt holds the cycles remaining in the current state, minus one.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      err_nx   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.wr_start) begin
               err_nx = bus.rd_start;
               if (CL_WR > 1) begin
                  state_nx = WR_LAT;
                  cnt_nx   = CNT_W'(CL_WR - 2);
               end else begin
                  state_nx = WR_BURST;
                  cnt_nx   = CNT_W'(BURST - 1);
               end
            end else if (bus.rd_start) begin
               if (CL_RD > 1) begin
                  state_nx = RD_LAT;
                  cnt_nx   = CNT_W'(CL_RD - 2);
               end else begin
                  state_nx = RD_BURST;
                  cnt_nx   = CNT_W'(BURST - 1);
               end
            end
         end
         WR_LAT: begin
            if (cnt == '0) begin
               state_nx = WR_BURST;
               cnt_nx   = CNT_W'(BURST - 1);
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         WR_BURST: begin
            if (cnt == '0) begin
               state_nx = WR_POST;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         WR_POST: begin
            state_nx = TURN;
         end
         RD_LAT: begin
            if (cnt == '0) begin
               state_nx = RD_BURST;
               cnt_nx   = CNT_W'(BURST - 1);
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         RD_BURST: begin
            if (cnt == '0) begin
               state_nx = TURN;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         TURN: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
      if ((state != IDLE) && (bus.wr_start || bus.rd_start)) begin
         err_nx = 1'b1;
      end
   end

   // DQ stays unmasked from read acceptance through the last capture edge
   assign rd_mask_nx = (state_nx == RD_LAT) || (state_nx == RD_BURST);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Control outputs: registered from next state
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         bus.busy         <= 1'b0;
         bus.protocol_err <= 1'b0;
         bus.wr_ack       <= 1'b0;
         bus.rd_valid     <= 1'b0;
      end else begin
         bus.busy         <= (state_nx != IDLE);
         bus.protocol_err <= err_nx;
         bus.wr_ack       <= (state_nx == WR_BURST);
         bus.rd_valid     <= (state == RD_BURST);
      end
   end

   // Write stage: acked word lands on dout one cycle after wr_ack; direction
   // covers those beats plus one postamble cycle for the delayed half-word.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         bus.dout        <= '0;
         bus.mo          <= 4'hF;
         bus.direction   <= 1'b0;
         bus.direction_r <= 1'b0;
      end else begin
         bus.direction   <= (state == WR_BURST) || (state == WR_POST);
         bus.direction_r <= bus.direction;
         if (bus.wr_ack) begin
            bus.dout <= bus.wr_data;
            bus.mo   <= ~bus.wr_be;
         end else begin
            bus.dout <= '0;
            bus.mo   <= rd_mask_nx ? 4'h0 : 4'hF;
         end
      end
   end

   // Read stage: capture di during burst beats, hold otherwise
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         bus.rd_data <= '0;
      end else if (state == RD_BURST) begin
         bus.rd_data <= bus.di;
      end
   end

endmodule
